// File: rtl/arm7tdmi_pkg.sv
// rtl/arm7tdmi_pkg.sv - shared types, field positions and helpers for the ARM7TDMI core slice
//
// Purpose : block data transfer (LDM/STM) sequencer state type, instruction
//           bit positions and a 16-bit population count helper.
// Ports   : none (package)
package arm7tdmi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } blk_state_t;

  localparam int BDT_P_BIT    = 24;
  localparam int BDT_U_BIT    = 23;
  localparam int BDT_S_BIT    = 22;
  localparam int BDT_W_BIT    = 21;
  localparam int BDT_L_BIT    = 20;
  localparam int BDT_RN_MSB   = 19;
  localparam int BDT_RN_LSB   = 16;
  localparam int BDT_LIST_MSB = 15;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/arm7tdmi_prio_enc16.sv
// rtl/arm7tdmi_prio_enc16.sv - lowest-set-bit priority encoder, 16 to 4
//
// Purpose : returns the index of the lowest set bit of a 16-bit mask.
// Ports   : i_mask  [15:0] register mask
//           o_idx   [3:0]  index of lowest set bit (0 when mask is empty)
//           o_valid        mask has at least one bit set
module arm7tdmi_prio_enc16 (
  input  logic [15:0] i_mask,
  output logic [3:0]  o_idx,
  output logic        o_valid
);

  // Scan from the top down so the last hit is the lowest set bit.
  always_comb begin
    o_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx = 4'(i);
      end
    end
  end

  assign o_valid = |i_mask;

endmodule

// File: rtl/arm7tdmi_block_xfer_seq.sv
// rtl/arm7tdmi_block_xfer_seq.sv - LDM/STM multi-cycle block transfer sequencer
//
// Purpose : takes one decoded block-transfer instruction plus the base value,
//           issues one word request per listed register (lowest register at the
//           lowest address), then signals done with the base writeback value.
// Ports   : clk, rst_n (async, active low)
//           start, instr[31:0], base_value     - launch interface (IDLE only)
//           busy                               - sequence in progress
//           mem_req, mem_addr, mem_we, mem_ack - memory request handshake
//           reg_addr, user_bank                - register file side of transfer
//           wb_en, wb_value                    - base writeback strobe / value
//           psr_restore, done                  - completion strobes
module arm7tdmi_block_xfer_seq
  import arm7tdmi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       instr,
  input  logic [ADDR_W-1:0] base_value,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [3:0]        reg_addr,
  output logic              user_bank,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_value,
  output logic              psr_restore,
  output logic              done
);

  blk_state_t        r_state;
  logic [15:0]       r_mask;
  logic [ADDR_W-1:0] r_wb_calc;
  logic              r_wb_pend;
  logic              r_psr_pend;
  logic              r_busy;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [3:0]        r_reg_addr;
  logic              r_user_bank;
  logic              r_wb_en;
  logic [ADDR_W-1:0] r_wb_value;
  logic              r_psr_restore;
  logic              r_done;

  // Launch-time decode of the incoming instruction.
  logic [15:0]       w_list;
  logic              w_empty;
  logic [15:0]       w_mask;
  logic [4:0]        w_cnt;
  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_start_addr;
  logic [ADDR_W-1:0] w_wb_calc;
  logic [3:0]        w_rn;
  logic              w_l;
  logic              w_s;
  logic              w_r15;
  logic              w_unused;

  // An empty list behaves as {R15} but still moves the base by 16 words.
  assign w_list   = instr[BDT_LIST_MSB:0];
  assign w_empty  = (w_list == 16'd0);
  assign w_mask   = w_empty ? 16'h8000 : w_list;
  assign w_cnt    = popcount16(w_mask);
  assign w_off    = w_empty ? ADDR_W'(64) : ADDR_W'({w_cnt, 2'b00});
  assign w_rn     = instr[BDT_RN_MSB:BDT_RN_LSB];
  assign w_l      = instr[BDT_L_BIT];
  assign w_s      = instr[BDT_S_BIT];
  assign w_r15    = w_mask[15];
  assign w_unused = ^instr[31:25];

  always_comb begin
    w_start_addr = base_value;
    case ({instr[BDT_P_BIT], instr[BDT_U_BIT]})
      2'b01:   w_start_addr = base_value;
      2'b11:   w_start_addr = base_value + ADDR_W'(4);
      2'b00:   w_start_addr = base_value - w_off + ADDR_W'(4);
      default: w_start_addr = base_value - w_off;
    endcase
  end

  assign w_wb_calc = instr[BDT_U_BIT] ? (base_value + w_off) : (base_value - w_off);

  // One encoder serves both launch (fresh mask) and ack (mask minus current bit),
  // so the next register number is ready to be registered on the same edge.
  logic [15:0] w_mask_cleared;
  logic [15:0] w_enc_in;
  logic [3:0]  w_enc_idx;
  logic        w_enc_valid;

  assign w_mask_cleared = r_mask & ~(16'h0001 << r_reg_addr);
  assign w_enc_in       = (r_state == IDLE) ? w_mask : w_mask_cleared;

  arm7tdmi_prio_enc16 u_prio_enc (
    .i_mask  (w_enc_in),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_mask        <= '0;
      r_wb_calc     <= '0;
      r_wb_pend     <= 1'b0;
      r_psr_pend    <= 1'b0;
      r_busy        <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_we      <= 1'b0;
      r_reg_addr    <= '0;
      r_user_bank   <= 1'b0;
      r_wb_en       <= 1'b0;
      r_wb_value    <= '0;
      r_psr_restore <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= XFER;
            r_mask      <= w_mask;
            r_wb_calc   <= w_wb_calc;
            // Loaded base value wins over writeback when Rn is in an LDM list.
            r_wb_pend   <= instr[BDT_W_BIT] & ~(w_l & w_mask[w_rn]);
            r_psr_pend  <= w_l & w_s & w_r15;
            r_busy      <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_addr  <= w_start_addr;
            r_mem_we    <= ~w_l;
            r_reg_addr  <= w_enc_idx;
            r_user_bank <= w_s & (~w_l | ~w_r15);
          end
        end
        XFER: begin
          if (mem_ack) begin
            r_mask <= w_mask_cleared;
            if (!w_enc_valid) begin
              r_state       <= DONE;
              r_mem_req     <= 1'b0;
              r_mem_addr    <= '0;
              r_mem_we      <= 1'b0;
              r_reg_addr    <= '0;
              r_user_bank   <= 1'b0;
              r_done        <= 1'b1;
              r_wb_en       <= r_wb_pend;
              r_wb_value    <= r_wb_calc;
              r_psr_restore <= r_psr_pend;
            end else begin
              r_mem_addr <= r_mem_addr + ADDR_W'(4);
              r_reg_addr <= w_enc_idx;
            end
          end
        end
        DONE: begin
          r_state       <= IDLE;
          r_busy        <= 1'b0;
          r_done        <= 1'b0;
          r_wb_en       <= 1'b0;
          r_wb_value    <= '0;
          r_psr_restore <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign mem_we      = r_mem_we;
  assign reg_addr    = r_reg_addr;
  assign user_bank   = r_user_bank;
  assign wb_en       = r_wb_en;
  assign wb_value    = r_wb_value;
  assign psr_restore = r_psr_restore;
  assign done        = r_done;

endmodule
